alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
// Parametrised multi-cycle EXE-stage ALU; successor to the 2-bit-command combinational ALU.
// Adds shifts, compares and an iterative XLEN-cycle multiplier.
// Uses a valid/ready handshake on both sides and a registered result, so the
// decode stage stalls on BUSY instead of the pipeline carrying a long combinational path.
// PARAMETERS
// XLEN    32  operand/result width (8..64, power of 2)
// MUL_EN  1   1: MUL/MULH/MULHU implemented; 0: those commands return 0 in 1 cycle
// PORTS
// CLK           in   1     clock, all state on rising edge
// RESET         in   1     asynchronous, active-high reset
// VALID_IN_SE   in   1     operands/command valid
// READY_OUT_SE  out  1     block can accept a command this cycle
// OP1_SE        in   XLEN  operand 1
// OP2_SE        in   XLEN  operand 2 (shift amount = OP2_SE[$clog2(XLEN)-1:0])
// CIN_SE        in   1     carry-in, used by ADD only
// CMD_SE        in   4     alu_cmd_e (see package)
// FLUSH_SE      in   1     synchronous kill of in-flight/pending result
// VALID_OUT_SE  out  1     RES_SE valid
// READY_IN_SE   in   1     downstream accepts result
// RES_SE        out  XLEN  result
// BUSY_SE       out  1     multiply iteration in progress
// BEHAVIOUR
// - Reset (async): state=IDLE, VALID_OUT_SE=0, RES_SE=0, BUSY_SE=0, READY_OUT_SE=1 after release.
// - Commands: 0 ADD op1+op2+cin (mod 2^XLEN); 1 AND; 2 OR; 3 XOR; 4 SLL; 5 SRL; 6 SRA;
//   7 SLT (signed, result 1/0); 8 SLTU; 9 MUL low XLEN; 10 MULH signed x signed high XLEN;
//   11 MULHU unsigned high XLEN; 12..15 reserved -> RES=0, 1-cycle latency.
// - Transfer in: VALID_IN_SE & READY_OUT_SE on a rising edge.
//   READY_OUT_SE = (state==IDLE) & (!VALID_OUT_SE | READY_IN_SE) & !FLUSH_SE.
// - Transfer out: VALID_OUT_SE & READY_IN_SE. RES_SE/VALID_OUT_SE hold stable until accepted.
// - Single-cycle ops: result registered on the accept edge; VALID_OUT_SE=1 the next cycle.
//   Latency 1; throughput 1/cycle when READY_IN_SE stays high.
// - FSM IDLE -> MUL (mul cmd accepted, MUL_EN=1) -> DONE (after XLEN iterations) -> IDLE (result
//   written to output reg). Latency XLEN+1 cycles from accept to VALID_OUT_SE.
//   BUSY_SE=1 in MUL and DONE.
// - Multiplier: radix-2 shift-add on |op1|,|op2| into a 2*XLEN accumulator.
//   MULH negates the 2*XLEN product when sign(op1)^sign(op2).
//   Edge case: most-negative x most-negative gives high = 2^(XLEN-2) (XLEN=32: 0x40000000).
// - DONE with VALID_OUT_SE=1 and READY_IN_SE=0: stay in DONE until the output register frees.
// - FLUSH_SE=1: next edge forces state=IDLE, VALID_OUT_SE=0 and BUSY_SE=0. READY_OUT_SE=0 that
//   cycle, so no new command is taken. FLUSH has priority over READY_IN_SE and over completion.
// - RESET asserted mid-multiply: immediate abort, no result emitted.
// PACKAGE / STRUCTURE
// - alu_pkg: typedef enum logic[3:0] alu_cmd_e {ALU_ADD..ALU_MULHU}; helper function is_mul(cmd).
// - Sub-module mul_iter: unsigned XLEN x XLEN iterative multiplier.
//   Interface: start, a, b -> done, prod[2*XLEN]; flush input.
//   alu_mc owns sign handling, the FSM and the output register.
// TESTING
// - ADD 0xFFFFFFFF+0x00000001 cin=1 -> RES=0x00000001, VALID_OUT one cycle after accept.
// - SRA 0x80000000 by 4 -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0; back-to-back issue, 1/cycle.
// - MULH 0x80000000 x 0x80000000 -> 0x40000000 at cycle 33; MUL 7x-3 -> 0xFFFFFFEB;
//   MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
// - Back-pressure: READY_IN_SE=0 for 5 cycles after result -> RES stable, READY_OUT_SE=0,
//   next cmd accepted only after drain.
// - FLUSH at iteration 10 of MUL -> VALID_OUT never set, BUSY=0 next cycle; next ADD 2+3 -> 5.
// - RESET pulse mid-MUL asynchronously clears outputs; MUL_EN=0 build: MUL 3x4 -> 0 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: command encoding and helpers shared by the multi-cycle ALU
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_AND   = 4'd1,
    ALU_OR    = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_SLL   = 4'd4,
    ALU_SRL   = 4'd5,
    ALU_SRA   = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLTU  = 4'd8,
    ALU_MUL   = 4'd9,
    ALU_MULH  = 4'd10,
    ALU_MULHU = 4'd11
  } alu_cmd_e;
  function automatic logic is_mul(input logic [3:0] cmd);
    return cmd inside {ALU_MUL, ALU_MULH, ALU_MULHU};
  endfunction
endpackage

// File: rtl/alu_mc_mul_iter.sv
// mul_iter: unsigned radix-2 shift-add multiplier, one partial product per cycle
module mul_iter #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic                done,
  output logic [2*XLEN-1:0]   prod
);
  localparam int CW = $clog2(XLEN) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, a_s;
  logic [2*XLEN-1:0] prod_q, prod_d, p_s;
  logic [XLEN:0] sum;
  // the start cycle already performs the first step, so XLEN-1 steps remain afterwards
  always_comb begin
    a_s = start ? a : a_q;
    p_s = start ? {{XLEN{1'b0}}, b} : prod_q;
    sum = {1'b0, p_s[2*XLEN-1:XLEN]} + (p_s[0] ? {1'b0, a_s} : '0);
    a_d = a_s;
    prod_d = (start || cnt_q != '0) ? {sum, p_s[XLEN-1:1]} : prod_q;
    cnt_d = flush ? '0 : start ? CW'(XLEN - 1) : cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
  end
  // iteration state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      a_q <= '0;
      prod_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q <= a_d;
      prod_q <= prod_d;
    end
  assign done = cnt_q == CW'(1);
  assign prod = prod_q;
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EXE ALU with valid/ready handshakes and iterative multiplier
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            VALID_IN_SE,
  output logic            READY_OUT_SE,
  input  logic [XLEN-1:0] OP1_SE,
  input  logic [XLEN-1:0] OP2_SE,
  input  logic            CIN_SE,
  input  logic [3:0]      CMD_SE,
  input  logic            FLUSH_SE,
  output logic            VALID_OUT_SE,
  input  logic            READY_IN_SE,
  output logic [XLEN-1:0] RES_SE,
  output logic            BUSY_SE
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
  state_e state_q, state_d;
  logic vout_q, vout_d, neg_q, neg_d, hi_q, hi_d;
  logic [XLEN-1:0] res_q, res_d, alu_res, op1_mag, op2_mag;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [SW-1:0] sh;
  logic start, mul_done, accept, signed_mul;
  assign sh = OP2_SE[SW-1:0];
  assign signed_mul = CMD_SE == ALU_MULH;
  assign op1_mag = (signed_mul && OP1_SE[XLEN-1]) ? -OP1_SE : OP1_SE;
  assign op2_mag = (signed_mul && OP2_SE[XLEN-1]) ? -OP2_SE : OP2_SE;
  assign prod_s = neg_q ? -prod : prod;
  assign READY_OUT_SE = state_q == IDLE && (!vout_q || READY_IN_SE) && !FLUSH_SE;
  assign accept = VALID_IN_SE && READY_OUT_SE;
  assign BUSY_SE = state_q != IDLE;
  assign VALID_OUT_SE = vout_q;
  assign RES_SE = res_q;
  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk(CLK), .rst(RESET), .start(start), .flush(FLUSH_SE),
    .a(op1_mag), .b(op2_mag), .done(mul_done), .prod(prod)
  );
  // single-cycle result; multiplies land here only when the multiplier is disabled
  always_comb begin
    alu_res = '0;
    case (CMD_SE)
      ALU_ADD:  alu_res = OP1_SE + OP2_SE + XLEN'(CIN_SE);
      ALU_AND:  alu_res = OP1_SE & OP2_SE;
      ALU_OR:   alu_res = OP1_SE | OP2_SE;
      ALU_XOR:  alu_res = OP1_SE ^ OP2_SE;
      ALU_SLL:  alu_res = OP1_SE << sh;
      ALU_SRL:  alu_res = OP1_SE >> sh;
      ALU_SRA:  alu_res = XLEN'($signed(OP1_SE) >>> sh);
      ALU_SLT:  alu_res = XLEN'($signed(OP1_SE) < $signed(OP2_SE));
      ALU_SLTU: alu_res = XLEN'(OP1_SE < OP2_SE);
      default:  alu_res = '0;
    endcase
  end
  // next state and output register; flush outranks drain and completion
  always_comb begin
    state_d = state_q;
    vout_d = vout_q && !READY_IN_SE;
    res_d = res_q;
    neg_d = neg_q;
    hi_d = hi_q;
    start = 1'b0;
    if (FLUSH_SE) begin
      state_d = IDLE;
      vout_d = 1'b0;
    end else if (accept && MUL_EN && is_mul(CMD_SE)) begin
      start = 1'b1;
      state_d = MUL;
      neg_d = signed_mul && (OP1_SE[XLEN-1] ^ OP2_SE[XLEN-1]);
      hi_d = CMD_SE != ALU_MUL;
    end else if (accept) begin
      res_d = alu_res;
      vout_d = 1'b1;
    end else if (state_q == MUL && mul_done) begin
      state_d = DONE;
    end else if (state_q == DONE && (!vout_q || READY_IN_SE)) begin
      res_d = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      vout_d = 1'b1;
      state_d = IDLE;
    end
  end
  // state and output registers
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      vout_q <= 1'b0;
      res_q <= '0;
      neg_q <= 1'b0;
      hi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vout_q <= vout_d;
      res_q <= res_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized scoreboard bench for alu_mc against an arithmetic reference model
`timescale 1ns/1ps
module tb_alu_mc;
  logic CLK, RESET, VALID_IN_SE, READY_OUT_SE, CIN_SE, FLUSH_SE, VALID_OUT_SE, READY_IN_SE, BUSY_SE;
  logic [31:0] OP1_SE, OP2_SE, RES_SE;
  logic [3:0] CMD_SE;
  logic v0, r0, vo0, b0;
  logic [3:0] cmd0;
  logic [31:0] a0, bb0, res0;
  int checks = 0, errors = 0, cyc = 0;
  bit rand_bp = 0;
  typedef struct {logic [31:0] res; int cyc; int lat;} exp_t;
  exp_t q[$];
  logic prev_v = 0, prev_r = 0, prev_f = 0;
  logic [31:0] prev_res = 0;

  alu_mc #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .VALID_IN_SE(VALID_IN_SE), .READY_OUT_SE(READY_OUT_SE),
    .OP1_SE(OP1_SE), .OP2_SE(OP2_SE), .CIN_SE(CIN_SE), .CMD_SE(CMD_SE), .FLUSH_SE(FLUSH_SE),
    .VALID_OUT_SE(VALID_OUT_SE), .READY_IN_SE(READY_IN_SE), .RES_SE(RES_SE), .BUSY_SE(BUSY_SE)
  );
  alu_mc #(.XLEN(32), .MUL_EN(1'b0)) dut0 (
    .CLK(CLK), .RESET(RESET), .VALID_IN_SE(v0), .READY_OUT_SE(r0),
    .OP1_SE(a0), .OP2_SE(bb0), .CIN_SE(1'b0), .CMD_SE(cmd0), .FLUSH_SE(1'b0),
    .VALID_OUT_SE(vo0), .READY_IN_SE(1'b1), .RES_SE(res0), .BUSY_SE(b0)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  always @(negedge CLK) if (rand_bp) READY_IN_SE = ($urandom % 3) != 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic cin);
    longint sa, sb, ps;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = sa * sb;
    u = {32'd0, a} * {32'd0, b};
    case (cmd)
      4'd0: return a + b + {31'd0, cin};
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a << b[4:0];
      4'd5: return a >> b[4:0];
      4'd6: return 32'($signed(a) >>> b[4:0]);
      4'd7: return {31'd0, sa < sb};
      4'd8: return {31'd0, a < b};
      4'd9: return u[31:0];
      4'd10: return ps[63:32];
      4'd11: return u[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // drive a command from a falling edge, wait for acceptance and log its expected response
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [31:0] exp, output int waited);
    VALID_IN_SE = 1; CMD_SE = cmd; OP1_SE = a; OP2_SE = b; CIN_SE = cin; waited = 0;
    forever begin
      #1;
      if (READY_OUT_SE) begin
        q.push_back('{exp, cyc, (cmd >= 4'd9 && cmd <= 4'd11) ? 33 : 1});
        @(negedge CLK);
        VALID_IN_SE = 0;
        return;
      end
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout actual=not_ready required=ready");
        @(negedge CLK);
        VALID_IN_SE = 0;
        return;
      end
      @(negedge CLK);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge CLK);
    chk("drain_empty", q.size(), 0);
  endtask

  // monitor: latency on first presentation, value on transfer, stability while stalled
  always @(negedge CLK) begin
    #2;
    if (prev_v && !prev_r && !prev_f) begin
      chk("hold_valid", VALID_OUT_SE, 1);
      chk("hold_res", RES_SE, prev_res);
    end
    if (VALID_OUT_SE && !(prev_v && !prev_r)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid actual=%0h required=none", RES_SE);
      end else chk("latency", cyc - q[0].cyc, q[0].lat);
    end
    if (VALID_OUT_SE && READY_IN_SE && q.size() != 0) begin
      chk("result", RES_SE, q[0].res);
      void'(q.pop_front());
    end
    prev_v = VALID_OUT_SE; prev_r = READY_IN_SE; prev_f = FLUSH_SE; prev_res = RES_SE;
  end

  initial begin
    int w;
    logic [3:0] c;
    logic [31:0] a, b;
    logic ci;
    RESET = 1; VALID_IN_SE = 0; OP1_SE = 0; OP2_SE = 0; CIN_SE = 0; CMD_SE = 0;
    FLUSH_SE = 0; READY_IN_SE = 1; v0 = 0; cmd0 = 0; a0 = 0; bb0 = 0;
    #1;
    chk("rst_res", RES_SE, 0);
    chk("rst_valid", VALID_OUT_SE, 0);
    chk("rst_busy", BUSY_SE, 0);
    repeat (2) @(negedge CLK);
    RESET = 0;
    #1 chk("rst_ready", READY_OUT_SE, 1);
    @(negedge CLK);
    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1, w);
    issue(4'd6, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, w);
    chk("b2b_wait_sra", w, 0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, w);
    chk("b2b_wait_slt", w, 0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, w);
    chk("b2b_wait_sltu", w, 0);
    drain();
    issue(4'd10, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, w);
    #1 chk("mul_busy", BUSY_SE, 1);
    drain();
    issue(4'd9, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, w);
    drain();
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, w);
    drain();
    READY_IN_SE = 0;
    issue(4'd0, 32'd10, 32'd20, 1'b0, 32'd30, w);
    VALID_IN_SE = 1; CMD_SE = 4'd3; OP1_SE = 32'hF0F0_F0F0; OP2_SE = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", READY_OUT_SE, 0);
      chk("bp_res", RES_SE, 30);
      @(negedge CLK);
    end
    READY_IN_SE = 1;
    issue(4'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 32'h0F0F_F0F0, w);
    drain();
    issue(4'd9, 32'd5, 32'd6, 1'b0, 32'd30, w);
    repeat (9) @(negedge CLK);
    FLUSH_SE = 1;
    q.delete();
    #1 chk("flush_ready", READY_OUT_SE, 0);
    @(negedge CLK);
    FLUSH_SE = 0;
    #1 chk("flush_busy", BUSY_SE, 0);
    chk("flush_valid", VALID_OUT_SE, 0);
    repeat (40) @(negedge CLK);
    chk("flush_no_result", VALID_OUT_SE, 0);
    issue(4'd0, 32'd2, 32'd3, 1'b0, 32'd5, w);
    drain();
    issue(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, model(4'd11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0), w);
    repeat (5) @(posedge CLK);
    #3 RESET = 1;
    q.delete();
    #1;
    chk("amid_valid", VALID_OUT_SE, 0);
    chk("amid_busy", BUSY_SE, 0);
    chk("amid_res", RES_SE, 0);
    #1 RESET = 0;
    repeat (40) @(negedge CLK);
    chk("amid_no_result", VALID_OUT_SE, 0);
    rand_bp = 1;
    for (int i = 0; i < 80; i++) begin
      c = 4'($urandom % 16); a = pick(); b = pick(); ci = 1'($urandom % 2);
      issue(c, a, b, ci, model(c, a, b, ci), w);
    end
    rand_bp = 0;
    @(negedge CLK);
    READY_IN_SE = 1;
    drain();
    v0 = 1; cmd0 = 4'd9; a0 = 32'd3; bb0 = 32'd4;
    #1 chk("nomul_ready", r0, 1);
    @(negedge CLK);
    v0 = 0;
    #1;
    chk("nomul_valid", vo0, 1);
    chk("nomul_res", res0, 0);
    chk("nomul_busy", b0, 0);
    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
